// File: rtl/expmul_pipe_vec.sv
// expmul_pipe_vec: three-stage online-softmax rescale pipeline.
// Each element is multiplied by 2^-(round(log2e*(b-a))). The exponent is applied as an
// integer arithmetic shift plus an optional 2^-0.5 half-step correction. Results are
// rounded and saturated. The final output stage also carries a sweep position counter.
module expmul_pipe_vec #(
    parameter int VEC_LEN = 65,
    parameter int DIFF_I  = 4,
    parameter int DIFF_F  = 4,
    parameter int V_I     = 9,
    parameter int V_F     = 17,
    parameter int GUARD_F = 6,
    parameter int HALF_EN = 1,
    parameter int SEQ_LEN = 128
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                vld_in,
    output logic                                rdy_out,
    input  logic [DIFF_I+DIFF_F-1:0]            a_in,
    input  logic [DIFF_I+DIFF_F-1:0]            b_in,
    input  logic [VEC_LEN*(V_I+V_F)-1:0]        v_in,
    input  logic                                bypass,
    output logic                                vld_out,
    input  logic                                rdy_in,
    output logic [VEC_LEN*(V_I+V_F)-1:0]        v_out,
    output logic [$clog2(SEQ_LEN)-1:0]          kv_counter,
    output logic                                last_out,
    output logic                                sat_out
);
    localparam int V_W  = V_I + V_F;
    localparam int VA_W = VEC_LEN * V_W;
    localparam int DW   = DIFF_I + DIFF_F;
    localparam int LW   = DIFF_I + 3 + DIFF_F;   // Q(DIFF_I+3).(DIFF_F) exponent
    localparam int LNW  = LW - 1;                // integer shift amount width
    localparam int XW   = V_W + GUARD_F;         // shifter width with guard bits
    localparam int KW   = $clog2(SEQ_LEN);

    // 0.25 in the exponent's Q format: rounding half-up to a 0.5 grid
    localparam logic signed [LW-1:0] RND_L = {{(LW-DIFF_F+1){1'b0}}, 1'b1, {(DIFF_F-2){1'b0}}};
    // half an output LSB expressed in guard-bit units
    localparam logic signed [XW+1:0] RND_G = {{(XW+2-GUARD_F){1'b0}}, 1'b1, {(GUARD_F-1){1'b0}}};
    localparam logic signed [XW+1:0] SAT_MAX = {{(XW+3-V_W){1'b0}}, {(V_W-1){1'b1}}};
    localparam logic signed [XW+1:0] SAT_MIN = {{(XW+3-V_W){1'b1}}, {(V_W-1){1'b0}}};

    // stage registers
    logic              vld1, vld2, vld3;
    logic [DW-1:0]     a1, b1;
    logic [VA_W-1:0]   v1, v2;
    logic              byp1;
    logic [LNW-1:0]    lint2;
    logic              half2;

    // a stage may accept when empty or when its contents move on this cycle
    logic rdy1, rdy2, rdy3;
    assign rdy3     = !vld3 || rdy_in;
    assign rdy2     = !vld2 || rdy3;
    assign rdy1     = !vld1 || rdy2;
    assign rdy_out  = rdy1;
    assign vld_out  = vld3;
    assign last_out = vld3 && (kv_counter == '0);

    // valid bits advance one stage per cycle unless the next stage is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            vld1 <= 1'b0;
            vld2 <= 1'b0;
            vld3 <= 1'b0;
        end else begin
            if (rdy1) vld1 <= vld_in;
            if (rdy2) vld2 <= vld1;
            if (rdy3) vld3 <= vld2;
        end
    end

    // S1 captures the raw beat
    always_ff @(posedge clk) begin
        if (rst) begin
            a1   <= '0;
            b1   <= '0;
            v1   <= '0;
            byp1 <= 1'b0;
        end else if (vld_in && rdy1) begin
            a1   <= a_in;
            b1   <= b_in;
            v1   <= v_in;
            byp1 <= bypass;
        end
    end

    // S2 exponent: L = -(1.4375*d) with d clamped to <= 0, rounded to a half step
    logic signed [DW:0]   d_full, d_clamp;
    logic signed [LW-1:0] d_ext, l_val, l_rnd, q_half;
    logic [LNW-1:0]       lint_next;
    logic                 half_next;

    always_comb begin
        d_full  = $signed({a1[DW-1], a1}) - $signed({b1[DW-1], b1});
        d_clamp = d_full[DW] ? d_full : '0;
        d_ext   = {{2{d_clamp[DW]}}, d_clamp};
        l_val   = -(d_ext + (d_ext >>> 1) - (d_ext >>> 4));
        l_rnd   = l_val + RND_L;
        q_half  = l_rnd >>> (DIFF_F - 1);   // L in units of 0.5
        lint_next = q_half[LW-1:1];
        half_next = (HALF_EN != 0) ? q_half[0] : 1'b0;
        if (byp1) begin
            lint_next = '0;
            half_next = 1'b0;
        end
    end

    // S2 registers shift amount, half-step flag and the vector
    always_ff @(posedge clk) begin
        if (rst) begin
            lint2 <= '0;
            half2 <= 1'b0;
            v2    <= '0;
        end else if (vld1 && rdy2) begin
            lint2 <= lint_next;
            half2 <= half_next;
            v2    <= v1;
        end
    end

    // S3 per-element scale, round and saturate
    logic [VA_W-1:0]    res_vec;
    logic [VEC_LEN-1:0] sat_vec;

    for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_elem
        logic signed [V_W-1:0]  v_e;
        logic signed [XW-1:0]   x_ext, x_sh;
        logic signed [XW+1:0]   x_w, x_h, x_r, y_full;
        logic signed [V_W-1:0]  y_sat;
        logic                   sat_e;

        assign v_e = v2[gi*V_W +: V_W];

        // shift by the integer exponent, then optionally multiply by 0.703125
        always_comb begin
            x_ext = {v_e, {GUARD_F{1'b0}}};
            if (32'(lint2) >= 32'(XW)) begin
                x_sh = '0;
            end else begin
                x_sh = x_ext >>> lint2;
            end
            x_w = {{2{x_sh[XW-1]}}, x_sh};
            if (half2) begin
                x_h = (x_w >>> 1) + (x_w >>> 3) + (x_w >>> 4) + (x_w >>> 6);
            end else begin
                x_h = x_w;
            end
            x_r    = x_h + RND_G;
            y_full = x_r >>> GUARD_F;
            sat_e  = 1'b0;
            y_sat  = y_full[V_W-1:0];
            if (y_full > SAT_MAX) begin
                y_sat = {1'b0, {(V_W-1){1'b1}}};
                sat_e = 1'b1;
            end else if (y_full < SAT_MIN) begin
                y_sat = {1'b1, {(V_W-1){1'b0}}};
                sat_e = 1'b1;
            end
        end

        assign res_vec[gi*V_W +: V_W] = y_sat;
        assign sat_vec[gi]            = sat_e;
    end

    // S3 output register holds steady while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v_out   <= '0;
            sat_out <= 1'b0;
        end else if (vld2 && rdy3) begin
            v_out   <= res_vec;
            sat_out <= |sat_vec;
        end
    end

    // sweep position of the presented beat, counting down and wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            kv_counter <= KW'(SEQ_LEN - 1);
        end else if (vld3 && rdy_in) begin
            kv_counter <= (kv_counter == '0) ? KW'(SEQ_LEN - 1) : kv_counter - 1'b1;
        end
    end

endmodule

// File: tb/tb_expmul_pipe_vec.sv
// Directed bench for expmul_pipe_vec with a small vector and a short sweep.
module tb_expmul_pipe_vec;
    localparam int VEC_LEN = 2;
    localparam int SEQ_LEN = 4;
    localparam int VW      = 26;

    logic                 clk = 1'b0;
    logic                 rst, vld_in, rdy_out, bypass, vld_out, rdy_in, last_out, sat_out;
    logic [7:0]           a_in, b_in;
    logic [VEC_LEN*VW-1:0] v_in, v_out;
    logic [1:0]           kv_counter;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    expmul_pipe_vec #(.VEC_LEN(VEC_LEN), .SEQ_LEN(SEQ_LEN)) dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
        .a_in(a_in), .b_in(b_in), .v_in(v_in), .bypass(bypass),
        .vld_out(vld_out), .rdy_in(rdy_in), .v_out(v_out),
        .kv_counter(kv_counter), .last_out(last_out), .sat_out(sat_out)
    );

    function automatic logic [VEC_LEN*VW-1:0] pack2(input int e0, input int e1);
        return {e1[VW-1:0], e0[VW-1:0]};
    endfunction

    function automatic int el(input logic [VEC_LEN*VW-1:0] v, input int i);
        logic signed [VW-1:0] s;
        s = v[i*VW +: VW];
        return int'(s);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        vld_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL reset_vld_out got %0b want 0", vld_out); end
        n_checks++; if (rdy_out !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_out got %0b want 1", rdy_out); end
        n_checks++; if (v_out !== '0) begin n_fail++; $display("FAIL reset_v_out got %h want 0", v_out); end
        n_checks++; if (kv_counter !== 2'd3) begin n_fail++; $display("FAIL reset_kv got %0d want 3", kv_counter); end
        n_checks++; if (last_out !== 1'b0) begin n_fail++; $display("FAIL reset_last got %0b want 0", last_out); end
        n_checks++; if (sat_out !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %0b want 0", sat_out); end
        $display("reset: checked idle outputs");
    endtask

    task automatic test_latency();
        @(negedge clk);
        rdy_in = 1'b1; a_in = 8'h10; b_in = 8'h10; bypass = 1'b0;
        v_in = pack2(32'h20000, 32'h155555);
        vld_in = 1'b1;
        @(negedge clk);
        vld_in = 1'b0;
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL lat_clk1 vld_out got %0b want 0", vld_out); end
        @(negedge clk);
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL lat_clk2 vld_out got %0b want 0", vld_out); end
        @(negedge clk);
        n_checks++; if (vld_out !== 1'b1) begin n_fail++; $display("FAIL lat_clk3 vld_out got %0b want 1", vld_out); end
        n_checks++; if (el(v_out, 0) !== 32'h20000) begin n_fail++; $display("FAIL lat_e0 got %h want 20000", el(v_out, 0)); end
        n_checks++; if (el(v_out, 1) !== 32'h155555) begin n_fail++; $display("FAIL lat_e1 got %h want 155555", el(v_out, 1)); end
        n_checks++; if (sat_out !== 1'b0) begin n_fail++; $display("FAIL lat_sat got %0b want 0", sat_out); end
        $display("latency: beat a=10 b=10 out e0=%h", el(v_out, 0));
        @(negedge clk);
    endtask

    task automatic test_scale();
        // a, b, element0, element1, bypass, expected element0, expected element1
        int ta [7] = '{8'h00, 8'h30, 8'h00, 8'h00, 8'h80, 8'h00, 8'h10};
        int tb [7] = '{8'h10, 8'h10, 8'h40, 8'h40, 8'h7F, 8'h08, 8'h10};
        int t0 [7] = '{32'h20000, -32'h20000, 32'h1ABCDE, 32'h20000, (1 << 25) - 1, 32'h20000, 12345};
        int t1 [7] = '{-32'h20000, 32'h12345, -5, -32'h20000, -(1 << 25), 3, -777};
        bit tp [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int x0 [7] = '{32'hB400, -32'h20000, 32'h1ABCDE, 32'h800, 4, 32'h16800, 12345};
        int x1 [7] = '{-32'hB400, 32'h12345, -5, -32'h800, -4, 2, -777};
        for (int k = 0; k < 7; k++) begin
            rdy_in = 1'b1; a_in = ta[k][7:0]; b_in = tb[k][7:0]; bypass = tp[k];
            v_in = pack2(t0[k], t1[k]);
            vld_in = 1'b1;
            @(negedge clk);
            vld_in = 1'b0;
            for (int i = 0; i < 10 && !vld_out; i++) @(negedge clk);
            n_checks++; if (vld_out !== 1'b1) begin n_fail++; $display("FAIL scale%0d_timeout vld_out got %0b want 1", k, vld_out); end
            n_checks++; if (el(v_out, 0) !== x0[k]) begin n_fail++; $display("FAIL scale%0d_e0 got %0d want %0d", k, el(v_out, 0), x0[k]); end
            n_checks++; if (el(v_out, 1) !== x1[k]) begin n_fail++; $display("FAIL scale%0d_e1 got %0d want %0d", k, el(v_out, 1), x1[k]); end
            n_checks++; if (sat_out !== 1'b0) begin n_fail++; $display("FAIL scale%0d_sat got %0b want 0", k, sat_out); end
            $display("scale%0d: a=%h b=%h byp=%0b out=%0d,%0d", k, ta[k][7:0], tb[k][7:0], tp[k], el(v_out, 0), el(v_out, 1));
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int e0 [4] = '{100, -200, 32'h1FFFFFF, -(1 << 25)};
        int e1 [4] = '{1, 2, 3, 4};
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit in_hs, out_hs;
        do_reset();
        rdy_in = 1'b0; a_in = 8'h00; b_in = 8'h00; bypass = 1'b1;
        while (got < 4 && cyc < 40) begin
            if (cyc == 6) begin
                n_checks++; if (sent != 3) begin n_fail++; $display("FAIL bp_accepted got %0d want 3", sent); end
                n_checks++; if (rdy_out !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_out got %0b want 0", rdy_out); end
                n_checks++; if (vld_out !== 1'b1) begin n_fail++; $display("FAIL bp_vld_out got %0b want 1", vld_out); end
            end
            if (cyc >= 3 && cyc < 6) begin
                n_checks++; if (el(v_out, 0) !== e0[0]) begin n_fail++; $display("FAIL bp_hold%0d got %0d want %0d", cyc, el(v_out, 0), e0[0]); end
            end
            if (cyc >= 6) rdy_in = 1'b1;
            vld_in = (sent < 4);
            if (sent < 4) v_in = pack2(e0[sent], e1[sent]);
            #1;
            in_hs  = vld_in && rdy_out;
            out_hs = vld_out && rdy_in;
            if (out_hs) begin
                n_checks++; if (el(v_out, 0) !== e0[got] || el(v_out, 1) !== e1[got]) begin
                    n_fail++; $display("FAIL bp_order%0d got %0d,%0d want %0d,%0d", got, el(v_out, 0), el(v_out, 1), e0[got], e1[got]);
                end
                $display("backpressure: beat %0d out=%0d,%0d", got, el(v_out, 0), el(v_out, 1));
                got++;
            end
            @(posedge clk);
            if (in_hs) sent++;
            @(negedge clk);
            cyc++;
        end
        vld_in = 1'b0;
        n_checks++; if (got != 4) begin n_fail++; $display("FAIL bp_count got %0d want 4", got); end
    endtask

    task automatic test_seq();
        int xkv [6] = '{3, 2, 1, 0, 3, 2};
        bit xlast [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit in_hs, out_hs;
        do_reset();
        rdy_in = 1'b1; a_in = 8'h00; b_in = 8'h00; bypass = 1'b1;
        while (got < 6 && cyc < 40) begin
            vld_in = (sent < 6);
            v_in = pack2(1000 + sent, -sent);
            #1;
            in_hs  = vld_in && rdy_out;
            out_hs = vld_out && rdy_in;
            if (out_hs) begin
                n_checks++; if (kv_counter !== xkv[got][1:0]) begin n_fail++; $display("FAIL seq%0d_kv got %0d want %0d", got, kv_counter, xkv[got]); end
                n_checks++; if (last_out !== xlast[got]) begin n_fail++; $display("FAIL seq%0d_last got %0b want %0b", got, last_out, xlast[got]); end
                n_checks++; if (el(v_out, 0) !== 1000 + got) begin n_fail++; $display("FAIL seq%0d_data got %0d want %0d", got, el(v_out, 0), 1000 + got); end
                $display("seq: beat %0d kv=%0d last=%0b", got, kv_counter, last_out);
                got++;
            end
            @(posedge clk);
            if (in_hs) sent++;
            @(negedge clk);
            cyc++;
        end
        vld_in = 1'b0;
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL seq_count got %0d want 6", got); end
    endtask

    task automatic test_reset_mid();
        int emitted = 0;
        // six handshakes from 3 modulo 4 leave the counter at 1
        #1;
        n_checks++; if (kv_counter !== 2'd1) begin n_fail++; $display("FAIL mid_kv_before got %0d want 1", kv_counter); end
        rdy_in = 1'b1; a_in = 8'h00; b_in = 8'h00; bypass = 1'b1;
        v_in = pack2(555, 556); vld_in = 1'b1;
        @(negedge clk);
        v_in = pack2(777, 778);
        @(negedge clk);
        rst = 1'b1; vld_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (vld_out !== 1'b0) begin n_fail++; $display("FAIL mid_vld_out got %0b want 0", vld_out); end
        n_checks++; if (kv_counter !== 2'd3) begin n_fail++; $display("FAIL mid_kv got %0d want 3", kv_counter); end
        n_checks++; if (last_out !== 1'b0) begin n_fail++; $display("FAIL mid_last got %0b want 0", last_out); end
        for (int i = 0; i < 8; i++) begin
            if (vld_out) emitted++;
            @(negedge clk);
        end
        n_checks++; if (emitted != 0) begin n_fail++; $display("FAIL mid_emitted got %0d want 0", emitted); end
        $display("reset_mid: emitted=%0d kv=%0d", emitted, kv_counter);
    endtask

    initial begin
        rst = 1'b1; vld_in = 1'b0; rdy_in = 1'b1; bypass = 1'b0;
        a_in = '0; b_in = '0; v_in = '0;
        test_reset();
        test_latency();
        test_scale();
        test_backpressure();
        test_seq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
